piso_serializer: RTL and testbench
==================================

PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter WIDTH, default 4, number of data bits per frame (legal range 2..16).
REQ-002 Parameter IDLE_LEVEL, default 1'b0, value driven on sout when no frame is in progress.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  reset, synchronous and active-high.
REQ-005 din  input  WIDTH  parallel word to serialize; sampled only on an accepted load.
REQ-006 load_valid  input  1  producer asserts when din holds a word to send.
REQ-007 load_ready  output  1  block can accept a word this cycle.
REQ-008 sout  output  1  serial data; this is the d input of the downstream shift register.
REQ-009 sout_valid  output  1  sout carries a data bit this cycle.
REQ-010 frame_done  output  1  one-cycle pulse coincident with the last bit of a frame.

Function
REQ-011 A load is accepted at a rising edge where load_valid=1 and load_ready=1; din is captured into an internal WIDTH-bit register.
REQ-012 Bits are sent MSB-first, one per clock, on registered outputs: after accepting at edge k, sout=din[WIDTH-1] during cycle k+1, and so on down to din[0] during cycle k+WIDTH.
REQ-013 Latency: 1 cycle from the accepting edge to the first bit. A frame occupies exactly WIDTH cycles.
REQ-014 sout_valid=1 during exactly the WIDTH bit cycles of a frame; otherwise 0.
REQ-015 When sout_valid=0, sout=IDLE_LEVEL.
REQ-016 FSM states: IDLE, SHIFT.
  - IDLE -> SHIFT on an accepted load.
  - SHIFT -> SHIFT on an accepted load in the last-bit cycle.
  - SHIFT -> IDLE in the last-bit cycle with no load.
REQ-017 Bit counter: cleared to 0 on every accepted load; incremented once per SHIFT cycle; the last-bit cycle is the one where the count equals WIDTH-1. The counter never wraps past WIDTH-1.
REQ-018 load_ready is combinational and equals !reset && (state==IDLE || last-bit cycle).
REQ-019 load_ready=0 during every SHIFT cycle except the last; load_valid in those cycles is ignored and din is not sampled.
REQ-020 Back-to-back loads: a load accepted in the last-bit cycle produces the new frame's MSB in the very next cycle, with no idle gap. sout_valid stays 1 across the frame boundary.
REQ-021 frame_done=1 exactly in each last-bit cycle, including back-to-back frames; otherwise 0.
REQ-022 Changes on din or load_valid while load_ready=0 have no effect on sout.

Reset
REQ-023 While reset=1 at a rising edge, the block takes these values and ignores load_valid:
  - state = IDLE
  - bit counter = 0
  - data register = 0
  - sout = IDLE_LEVEL
  - sout_valid = 0
  - frame_done = 0
REQ-024 Reset asserted mid-frame aborts the frame at that edge. Remaining bits are discarded, and frame_done is not pulsed for the aborted frame.
REQ-025 In the first cycle after reset deasserts, load_ready=1, and a load in that cycle is accepted normally.

Structure
REQ-026 A shared package holds the state enumeration (IDLE, SHIFT) and the default width constant of 4. The downstream shift register uses the same width constant.
REQ-027 One sub-module is used: ser_bit_counter, a modulo-WIDTH counter with clear, enable and last outputs. All other logic is in piso_serializer.

Verification
REQ-028 Reset, then load din=4'b1011 at t0 -> sout sequence 1,0,1,1 over the next 4 cycles with sout_valid=1. frame_done=1 on the 4th bit only. A downstream 4-bit shift register sampling sout holds 1011, with the first bit in its oldest position.
REQ-029 load_valid held high with 4'b1100, then 4'b0011 -> 8 consecutive valid bits 1,1,0,0,0,0,1,1 with no gap. frame_done pulses on bits 4 and 8. load_ready is high only in cycles 4 and 8.
REQ-030 Load 4'b1111; in bit cycle 2, drive din=4'b0000 with load_valid=1 -> output remains 1,1,1,1, and the second word is accepted only in bit cycle 4.
REQ-031 Load 4'b1010; assert reset during bit 2 -> next cycle sout=IDLE_LEVEL, sout_valid=0, frame_done never pulses. After reset deasserts, load 4'b0110 -> sout 0,1,1,0.
REQ-032 No load for 10 cycles after reset -> sout=IDLE_LEVEL, sout_valid=0, frame_done=0, load_ready=1 throughout.
REQ-033 WIDTH=8 build: load 8'hA5 -> sout sequence 1,0,1,0,0,1,0,1, with frame_done on the 8th bit.

Source files
------------

// File: rtl/piso_serializer_pkg.sv
// piso_serializer_pkg: shared state encoding and default frame width for the serializer and its downstream shift register
package piso_serializer_pkg;
  localparam int DEFAULT_WIDTH = 4;
  typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake (din/load_valid/load_ready) plus serial output (sout/sout_valid/frame_done); master = producer/consumer side, slave = serializer
interface piso_serializer_if #(parameter int WIDTH = piso_serializer_pkg::DEFAULT_WIDTH);
  logic [WIDTH-1:0] din;
  logic load_valid;
  logic load_ready;
  logic sout;
  logic sout_valid;
  logic frame_done;
  modport master (output din, load_valid, input load_ready, sout, sout_valid, frame_done);
  modport slave (input din, load_valid, output load_ready, sout, sout_valid, frame_done);
endinterface

// File: rtl/ser_bit_counter.sv
// ser_bit_counter: saturating modulo-WIDTH bit counter; clk/rst, clr restarts at 0, en advances, count/last report position
module ser_bit_counter import piso_serializer_pkg::*; #(
  parameter int WIDTH = DEFAULT_WIDTH,
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic [CW-1:0] count,
  output logic last
);
  logic [CW-1:0] count_q, count_d;
  assign last = count_q == CW'(WIDTH - 1);
  assign count = count_q;
  always_comb count_d = clr ? '0 : (en && !last) ? count_q + 1'b1 : count_q;
  always_ff @(posedge clk)
    if (rst) count_q <= '0;
    else count_q <= count_d;
endmodule

// File: rtl/piso_serializer.sv
// piso_serializer: MSB-first parallel-to-serial converter; clk/reset plain ports, bus carries load handshake and registered serial outputs
module piso_serializer import piso_serializer_pkg::*; #(
  parameter int   WIDTH      = DEFAULT_WIDTH,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic clk,
  input logic reset,
  piso_serializer_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  state_t state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic sout_q, sout_d, sout_valid_q, sout_valid_d, frame_done_q, frame_done_d;
  logic [CW-1:0] count;
  logic cnt_last, last, accept, shifting;
  ser_bit_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk(clk), .rst(reset), .clr(accept), .en(shifting), .count(count), .last(cnt_last)
  );
  assign shifting = state_q == SHIFT;
  assign last = shifting && cnt_last;
  assign bus.load_ready = !reset && (state_q == IDLE || last);
  assign accept = bus.load_valid && bus.load_ready;
  assign bus.sout = sout_q;
  assign bus.sout_valid = sout_valid_q;
  assign bus.frame_done = frame_done_q;
  // sout_q already shows data_q[WIDTH-1], so the next bit out is data_q[WIDTH-2];
  // frame_done is registered one cycle early so it lands on the last bit.
  always_comb begin
    state_d = accept ? SHIFT : last ? IDLE : state_q;
    data_d = accept ? bus.din : shifting ? data_q << 1 : data_q;
    sout_d = accept ? bus.din[WIDTH-1] : (shifting && !last) ? data_q[WIDTH-2] : IDLE_LEVEL;
    sout_valid_d = accept || (shifting && !last);
    frame_done_d = shifting && count == CW'(WIDTH - 2);
  end
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      data_q <= '0;
      sout_q <= IDLE_LEVEL;
      sout_valid_q <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q <= data_d;
      sout_q <= sout_d;
      sout_valid_q <= sout_valid_d;
      frame_done_q <= frame_done_d;
    end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed scenario bench for 4-bit (idle 0) and 8-bit (idle 1) serializers
module tb_piso_serializer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vec = 0;
  int bad = 0;
  always #5 clk = ~clk;
  piso_serializer_if #(.WIDTH(4)) b4 ();
  piso_serializer_if #(.WIDTH(8)) b8 ();
  piso_serializer #(.WIDTH(4), .IDLE_LEVEL(1'b0)) u4 (.clk(clk), .reset(rst), .bus(b4.slave));
  piso_serializer #(.WIDTH(8), .IDLE_LEVEL(1'b1)) u8 (.clk(clk), .reset(rst), .bus(b8.slave));
  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end
  task automatic test_reset;
    rst = 1'b1; b4.din = 4'b1111; b4.load_valid = 1'b1; b8.din = 8'hFF; b8.load_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      vec++;
      if (b4.sout !== 1'b0 || b4.sout_valid !== 1'b0 || b4.frame_done !== 1'b0 || b4.load_ready !== 1'b0) begin
        bad++;
        $display("FAIL reset_hold: sout=%0b valid=%0b done=%0b ready=%0b want 0 0 0 0", b4.sout, b4.sout_valid, b4.frame_done, b4.load_ready);
      end
    end
    rst = 1'b0; b4.load_valid = 1'b0;
    #1;
    vec++;
    if (b4.load_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_release_ready: got %0b want 1", b4.load_ready);
    end
  endtask
  task automatic test_idle;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vec++;
      if (b4.sout !== 1'b0 || b4.sout_valid !== 1'b0 || b4.frame_done !== 1'b0 || b4.load_ready !== 1'b1) begin
        bad++;
        $display("FAIL idle_%0d: sout=%0b valid=%0b done=%0b ready=%0b want 0 0 0 1", i, b4.sout, b4.sout_valid, b4.frame_done, b4.load_ready);
      end
    end
  endtask
  task automatic test_basic;
    logic [3:0] sr = 4'b0000;
    logic [3:0] w = 4'b1011;
    @(negedge clk);
    b4.din = w; b4.load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b4.load_valid = 1'b0;
      sr = {sr[2:0], b4.sout};
      vec++;
      if (b4.sout !== w[3-i] || b4.sout_valid !== 1'b1 || b4.frame_done !== (i == 3)) begin
        bad++;
        $display("FAIL basic_bit%0d: sout=%0b valid=%0b done=%0b want %0b 1 %0b", i, b4.sout, b4.sout_valid, b4.frame_done, w[3-i], i == 3);
      end
    end
    @(negedge clk);
    vec++;
    if (b4.sout !== 1'b0 || b4.sout_valid !== 1'b0 || b4.frame_done !== 1'b0) begin
      bad++;
      $display("FAIL basic_after: sout=%0b valid=%0b done=%0b want 0 0 0", b4.sout, b4.sout_valid, b4.frame_done);
    end
    vec++;
    if (sr !== 4'b1011) begin
      bad++;
      $display("FAIL basic_downstream: got %0b want 1011", sr);
    end
  endtask
  task automatic test_back_to_back;
    logic [7:0] seq = 8'b11000011;
    @(negedge clk);
    b4.din = 4'b1100; b4.load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec++;
      if (b4.sout !== seq[7-i] || b4.sout_valid !== 1'b1 || b4.frame_done !== (i == 3 || i == 7) || b4.load_ready !== (i == 3 || i == 7)) begin
        bad++;
        $display("FAIL b2b_bit%0d: sout=%0b valid=%0b done=%0b ready=%0b want %0b 1 %0b %0b", i, b4.sout, b4.sout_valid, b4.frame_done, b4.load_ready, seq[7-i], i == 3 || i == 7, i == 3 || i == 7);
      end
      if (i == 3) b4.din = 4'b0011;
      if (i == 7) b4.load_valid = 1'b0;
    end
    @(negedge clk);
    vec++;
    if (b4.sout_valid !== 1'b0 || b4.frame_done !== 1'b0) begin
      bad++;
      $display("FAIL b2b_after: valid=%0b done=%0b want 0 0", b4.sout_valid, b4.frame_done);
    end
  endtask
  task automatic test_ignore_busy;
    logic [7:0] seq = 8'b11110000;
    @(negedge clk);
    b4.din = 4'b1111; b4.load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vec++;
      if (b4.sout !== seq[7-i] || b4.sout_valid !== 1'b1 || b4.frame_done !== (i == 3 || i == 7) || b4.load_ready !== (i == 3 || i == 7)) begin
        bad++;
        $display("FAIL busy_bit%0d: sout=%0b valid=%0b done=%0b ready=%0b want %0b 1 %0b %0b", i, b4.sout, b4.sout_valid, b4.frame_done, b4.load_ready, seq[7-i], i == 3 || i == 7, i == 3 || i == 7);
      end
      if (i == 0) b4.load_valid = 1'b0;
      if (i == 1) begin b4.din = 4'b0000; b4.load_valid = 1'b1; end
      if (i == 4) b4.load_valid = 1'b0;
    end
    @(negedge clk);
    vec++;
    if (b4.sout_valid !== 1'b0) begin
      bad++;
      $display("FAIL busy_after: valid=%0b want 0", b4.sout_valid);
    end
  endtask
  task automatic test_reset_abort;
    logic [3:0] w = 4'b0110;
    @(negedge clk);
    b4.din = 4'b1010; b4.load_valid = 1'b1;
    @(negedge clk);
    b4.load_valid = 1'b0;
    @(negedge clk);
    vec++;
    if (b4.sout !== 1'b0 || b4.sout_valid !== 1'b1) begin
      bad++;
      $display("FAIL abort_bit2: sout=%0b valid=%0b want 0 1", b4.sout, b4.sout_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    vec++;
    if (b4.sout !== 1'b0 || b4.sout_valid !== 1'b0 || b4.frame_done !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset: sout=%0b valid=%0b done=%0b want 0 0 0", b4.sout, b4.sout_valid, b4.frame_done);
    end
    rst = 1'b0;
    #1;
    vec++;
    if (b4.load_ready !== 1'b1) begin
      bad++;
      $display("FAIL abort_ready: got %0b want 1", b4.load_ready);
    end
    b4.din = w; b4.load_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      b4.load_valid = 1'b0;
      vec++;
      if (b4.sout !== w[3-i] || b4.sout_valid !== 1'b1 || b4.frame_done !== (i == 3)) begin
        bad++;
        $display("FAIL abort_reload_bit%0d: sout=%0b valid=%0b done=%0b want %0b 1 %0b", i, b4.sout, b4.sout_valid, b4.frame_done, w[3-i], i == 3);
      end
    end
    @(negedge clk);
  endtask
  task automatic test_width8;
    logic [7:0] w = 8'hA5;
    @(negedge clk);
    vec++;
    if (b8.sout !== 1'b1 || b8.sout_valid !== 1'b0 || b8.load_ready !== 1'b1) begin
      bad++;
      $display("FAIL w8_idle: sout=%0b valid=%0b ready=%0b want 1 0 1", b8.sout, b8.sout_valid, b8.load_ready);
    end
    b8.din = w; b8.load_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      b8.load_valid = 1'b0;
      vec++;
      if (b8.sout !== w[7-i] || b8.sout_valid !== 1'b1 || b8.frame_done !== (i == 7) || b8.load_ready !== (i == 7)) begin
        bad++;
        $display("FAIL w8_bit%0d: sout=%0b valid=%0b done=%0b ready=%0b want %0b 1 %0b %0b", i, b8.sout, b8.sout_valid, b8.frame_done, b8.load_ready, w[7-i], i == 7, i == 7);
      end
    end
    @(negedge clk);
    vec++;
    if (b8.sout !== 1'b1 || b8.sout_valid !== 1'b0 || b8.frame_done !== 1'b0) begin
      bad++;
      $display("FAIL w8_after: sout=%0b valid=%0b done=%0b want 1 0 0", b8.sout, b8.sout_valid, b8.frame_done);
    end
  endtask
  initial begin
    test_reset;
    test_idle;
    test_basic;
    test_back_to_back;
    test_ignore_busy;
    test_reset_abort;
    test_width8;
    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end
endmodule
